// File: rtl/vehicle_counter_pkg.sv
// Shared widths, gate-event encoding and saturating helper for the vehicle_counter block.
// Optional statistics outputs are enabled by defining VEHICLE_COUNTER_STATS_EN.
package vehicle_counter_pkg;

    localparam int COUNT_W = 6;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_ENTRY = 2'b01,
        EV_EXIT  = 2'b10,
        EV_BOTH  = 2'b11
    } gate_event_t;

    function automatic gate_event_t classify_event(input logic entry_pulse, input logic exit_pulse);
        gate_event_t ev;
        unique case ({exit_pulse, entry_pulse})
            2'b01:   ev = EV_ENTRY;
            2'b10:   ev = EV_EXIT;
            2'b11:   ev = EV_BOTH;
            default: ev = EV_NONE;
        endcase
        return ev;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/vehicle_counter_edge_detect.sv
// Rising-edge detector for a gate sensor level; the pulse is combinational so the
// event takes effect at the same clock edge that first samples the level high.
module vc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/vehicle_counter.sv
// Parking occupancy counter with runtime-adjustable capacity, clamped by MAX_CAPACITY.
// Define VEHICLE_COUNTER_STATS_EN to add saturating entry/exit/rejected totals.
module vehicle_counter
    import vehicle_counter_pkg::*;
#(
    parameter int MAX_CAPACITY = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entry_passed,
    input  logic               exit_passed,
    input  logic [COUNT_W-1:0] max_capacity,
    output logic [COUNT_W-1:0] vehicle_count,
    output logic [COUNT_W-1:0] available_spaces,
    output logic               parking_full
`ifdef VEHICLE_COUNTER_STATS_EN
    ,
    output logic [STAT_W-1:0]  entry_total,
    output logic [STAT_W-1:0]  exit_total,
    output logic [STAT_W-1:0]  rejected_total
`endif
);

    localparam logic [COUNT_W-1:0] CAP_LIMIT = COUNT_W'(MAX_CAPACITY);

    logic               entry_pulse;
    logic               exit_pulse;
    logic [COUNT_W-1:0] cap;
    gate_event_t        ev;
    logic               entry_ok;
    logic               exit_ok;
    logic [COUNT_W-1:0] count_nxt;

    vc_edge_detect u_entry_edge (
        .clk   (clk),
        .reset (reset),
        .level (entry_passed),
        .pulse (entry_pulse)
    );

    vc_edge_detect u_exit_edge (
        .clk   (clk),
        .reset (reset),
        .level (exit_passed),
        .pulse (exit_pulse)
    );

    assign cap = (max_capacity < CAP_LIMIT) ? max_capacity : CAP_LIMIT;

    // Simultaneous entry and exit cancel out, so only single-gate events move the count.
    always_comb begin
        ev       = classify_event(entry_pulse, exit_pulse);
        entry_ok = 1'b0;
        exit_ok  = 1'b0;
        unique case (ev)
            EV_ENTRY: entry_ok = (vehicle_count < cap);
            EV_EXIT:  exit_ok  = (vehicle_count != '0);
            default:  ;
        endcase
    end

    always_comb begin
        count_nxt = vehicle_count;
        if (entry_ok) begin
            count_nxt = vehicle_count + COUNT_W'(1);
        end else if (exit_ok) begin
            count_nxt = vehicle_count - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vehicle_count <= '0;
        end else begin
            vehicle_count <= count_nxt;
        end
    end

    // A capacity lowered below the current count reads as full with no free space.
    assign available_spaces = (vehicle_count < cap) ? (cap - vehicle_count) : '0;
    assign parking_full     = (vehicle_count >= cap);

`ifdef VEHICLE_COUNTER_STATS_EN
    logic entry_rej;

    assign entry_rej = (ev == EV_ENTRY) && !entry_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_total    <= '0;
            exit_total     <= '0;
            rejected_total <= '0;
        end else begin
            if (entry_ok) begin
                entry_total <= sat_inc(entry_total);
            end
            if (exit_ok) begin
                exit_total <= sat_inc(exit_total);
            end
            if (entry_rej) begin
                rejected_total <= sat_inc(rejected_total);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vehicle_counter.sv
// Scoreboard bench for vehicle_counter: directed scenarios then random gate traffic,
// checked against an occupancy model built from the counting rules.
module tb_vehicle_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_passed = 1'b0;
    logic       exit_passed = 1'b0;
    logic [5:0] max_capacity = 6'd63;
    logic [5:0] vehicle_count;
    logic [5:0] available_spaces;
    logic       parking_full;
`ifdef VEHICLE_COUNTER_STATS_EN
    logic [15:0] entry_total;
    logic [15:0] exit_total;
    logic [15:0] rejected_total;
`endif

    vehicle_counter #(.MAX_CAPACITY(63)) dut (
        .clk              (clk),
        .reset            (reset),
        .entry_passed     (entry_passed),
        .exit_passed      (exit_passed),
        .max_capacity     (max_capacity),
        .vehicle_count    (vehicle_count),
        .available_spaces (available_spaces),
        .parking_full     (parking_full)
`ifdef VEHICLE_COUNTER_STATS_EN
        ,
        .entry_total      (entry_total),
        .exit_total       (exit_total),
        .rejected_total   (rejected_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int avail;
        int full;
        int ent;
        int ext;
        int rej;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int occ = 0;
    int prev_e = 0;
    int prev_x = 0;
    int tot_e = 0;
    int tot_x = 0;
    int tot_r = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int eff_cap(input int mc);
        return (mc < 63) ? mc : 63;
    endfunction

    function automatic exp_t model_outputs(input int mc);
        exp_t e;
        int c;
        c       = eff_cap(mc);
        e.cnt   = occ;
        e.avail = (occ < c) ? c - occ : 0;
        e.full  = (occ >= c) ? 1 : 0;
        e.ent   = tot_e;
        e.ext   = tot_x;
        e.rej   = tot_r;
        return e;
    endfunction

    // One clock of stimulus: apply levels, advance the model, queue the post-edge result.
    task automatic step(input int e, input int x, input int mc);
        int rise_e;
        int rise_x;
        @(negedge clk);
        entry_passed = e[0];
        exit_passed  = x[0];
        max_capacity = mc[5:0];
        rise_e = (e != 0 && prev_e == 0) ? 1 : 0;
        rise_x = (x != 0 && prev_x == 0) ? 1 : 0;
        prev_e = e;
        prev_x = x;
        if (rise_e == 1 && rise_x == 0) begin
            if (occ < eff_cap(mc)) begin
                occ++;
                if (tot_e < 65535) tot_e++;
            end else begin
                if (tot_r < 65535) tot_r++;
            end
        end else if (rise_x == 1 && rise_e == 0) begin
            if (occ > 0) begin
                occ--;
                if (tot_x < 65535) tot_x++;
            end
        end
        exp_q.push_back(model_outputs(mc));
    endtask

    task automatic pulse_entry(input int mc);
        step(1, 0, mc);
        step(0, 0, mc);
    endtask

    task automatic pulse_exit(input int mc);
        step(0, 1, mc);
        step(0, 0, mc);
    endtask

    // Outputs are sampled 1 ns after the active edge whenever a result is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("vehicle_count", int'(vehicle_count), e.cnt);
                chk("available_spaces", int'(available_spaces), e.avail);
                chk("parking_full", int'(parking_full), e.full);
`ifdef VEHICLE_COUNTER_STATS_EN
                chk("entry_total", int'(entry_total), e.ent);
                chk("exit_total", int'(exit_total), e.ext);
                chk("rejected_total", int'(rejected_total), e.rej);
`endif
            end
        end
    end

    task automatic check_async_reset(input int mc);
        exp_t e;
        @(negedge clk);
        #2;
        reset = 1'b0;
        entry_passed = 1'b0;
        exit_passed  = 1'b0;
        max_capacity = mc[5:0];
        occ = 0; prev_e = 0; prev_x = 0;
        tot_e = 0; tot_x = 0; tot_r = 0;
        #1;
        e = model_outputs(mc);
        chk("reset_count", int'(vehicle_count), e.cnt);
        chk("reset_available", int'(available_spaces), e.avail);
        chk("reset_full", int'(parking_full), e.full);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        int mc;
        int e_lvl;
        int x_lvl;

        check_async_reset(63);

        // six single-cycle entries
        for (int i = 0; i < 6; i++) pulse_entry(63);
        // four exits then a simultaneous entry+exit
        for (int i = 0; i < 4; i++) pulse_exit(63);
        step(1, 1, 63);
        step(0, 0, 63);

        // fill to the limit, one rejected entry, one exit
        while (occ < 63) pulse_entry(63);
        pulse_entry(63);
        pulse_exit(63);

        // capacity lowered below the count, then restored
        step(0, 0, 10);
        pulse_entry(10);
        pulse_exit(10);
        pulse_entry(63);
        pulse_exit(63);
        step(0, 0, 63);

        // mid-operation reset, then an exit at zero
        check_async_reset(63);
        pulse_exit(63);

        // entry held high for five cycles counts once
        for (int i = 0; i < 5; i++) step(1, 0, 63);
        step(0, 0, 63);

        // zero capacity rejects everything
        pulse_entry(0);
        step(1, 1, 0);
        step(0, 0, 0);

        // random traffic with occasional capacity changes and resets
        mc = 63;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) mc = int'($urandom_range(0, 63));
            else if (r < 5) mc = 63;
            e_lvl = ($urandom_range(0, 99) < 55) ? 1 : 0;
            x_lvl = ($urandom_range(0, 99) < 35) ? 1 : 0;
            if (i % 997 == 500) begin
                check_async_reset(mc);
            end else begin
                step(e_lvl, x_lvl, mc);
            end
        end
        step(0, 0, 63);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vehicle_counter.md
VEHICLE_COUNTER -- requirements
Module: vehicle_counter

Interface
REQ-001 SHALL have parameter MAX_CAPACITY, default 63; hard upper bound on occupancy, legal range 1..63.
REQ-002 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit; asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port entry_passed, input, 1 bit; vehicle has cleared the entry gate.
REQ-005 SHALL have port exit_passed, input, 1 bit; vehicle has cleared the exit gate.
REQ-006 SHALL have port max_capacity, input, 6 bits; runtime capacity, may change at any time.
REQ-007 SHALL have port vehicle_count, output, 6 bits; current occupancy (registered).
REQ-008 SHALL have port available_spaces, output, 6 bits; free spaces.
REQ-009 SHALL have port parking_full, output, 1 bit; no free space.

Function
REQ-010 SHALL define effective capacity cap = min(max_capacity, MAX_CAPACITY), evaluated combinationally every cycle.
REQ-011 SHALL detect an entry event on each 0->1 transition of entry_passed (previous value registered), one event per transition regardless of pulse length; exit events detected likewise.
REQ-012 SHALL, on entry event only, increment vehicle_count at the same clock edge the rising input is sampled, if vehicle_count < cap; otherwise count unchanged (entry rejected).
REQ-013 SHALL, on exit event only, decrement vehicle_count if vehicle_count > 0; at 0 count unchanged (no wrap to 63).
REQ-014 SHALL, on simultaneous entry and exit events, leave vehicle_count unchanged in all cases, including count 0 and full.
REQ-015 SHALL drive available_spaces = cap - vehicle_count when vehicle_count < cap, else 0; combinational from registered count and current cap.
REQ-016 SHALL drive parking_full = 1 when vehicle_count >= cap, else 0; combinational.
REQ-017 SHALL, when capacity is lowered below vehicle_count, retain vehicle_count, block entries, allow exits, and report available_spaces 0, parking_full 1.
REQ-018 SHALL treat cap 0 as permanently full: all entries rejected.

Reset
REQ-019 SHALL, while reset is 0, asynchronously force vehicle_count 0 and edge-detect history registers 0.
REQ-020 SHALL consequently present available_spaces = cap and parking_full = (cap == 0) during and after reset.
REQ-021 SHALL, on reset assertion mid-operation, discard any in-flight event; first event after release is detected only from a fresh 0->1 transition.

Configuration
REQ-022 SHALL support macro VEHICLE_COUNTER_STATS_EN; when defined, add outputs entry_total, exit_total, rejected_total (16 bits each), counting accepted entries, accepted exits and rejected entries, saturating at 65535, reset to 0; simultaneous entry+exit counts as neither accepted nor rejected.
REQ-023 SHALL, without VEHICLE_COUNTER_STATS_EN, omit those ports and registers entirely, with core behaviour identical.

Structure
REQ-024 SHALL place constants COUNT_W = 6 and STAT_W = 16 in shared package vehicle_counter_pkg.
REQ-025 SHALL implement edge detection in sub-module vc_edge_detect (clk, reset, level in, pulse out), instantiated once per gate input.

Verification
REQ-026 SHALL check: reset, max_capacity 63, six single-cycle entry pulses -> count 6, available 57, full 0.
REQ-027 SHALL check: from count 6, four exits then one simultaneous entry+exit pulse -> count 2, available 61.
REQ-028 SHALL check: fill to 63 -> full 1, available 0; one further entry -> count stays 63, rejected_total +1 when STATS enabled; one exit -> count 62, full 0.
REQ-029 SHALL check: count 62, max_capacity set to 10 -> available 0, full 1 within one cycle; max_capacity back to 63 -> available 1, full 0.
REQ-030 SHALL check: reset asserted mid-operation -> count 0, available 63, full 0 asynchronously; then exit pulse -> count stays 0.
REQ-031 SHALL check: entry_passed held high 5 cycles -> count increments exactly once.
